// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming helpers: sizing, encode/extract, decode result type.
// Pure functions and types only; no clocked logic, no flow control.
package hamming_pkg;

    localparam int MAX_W = 64;
    localparam int MAX_P = 8;
    localparam int MAX_N = MAX_W + MAX_P + 1;

    localparam int POS_OVERALL = 0;
    localparam int POS_D0      = 3;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic [MAX_P-1:0] syndrome;
        logic             sec;
        logic             ded;
    } dec_res_t;

    function automatic int calc_p(input int width);
        int p;
        p = 1;
        while ((1 << p) < width + p + 1) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Data bits fill the non-power-of-two positions from 3 upward, LSB first.
    function automatic logic [MAX_N-1:0] encode(input logic [MAX_W-1:0] data, input int width);
        logic [MAX_N-1:0] cw;
        logic             par;
        int               n;
        int               di;
        n  = width + calc_p(width) + 1;
        cw = '0;
        di = 0;
        for (int pos = POS_D0; pos < MAX_N; pos++) begin
            if (pos < n && !is_pow2(pos)) begin
                cw[pos] = data[di];
                di++;
            end
        end
        for (int k = 0; k < MAX_P; k++) begin
            if ((1 << k) < n) begin
                par = 1'b0;
                for (int pos = 1; pos < MAX_N; pos++)
                    if (pos < n && (pos & (1 << k)) != 0) par = par ^ cw[pos];
                cw[1 << k] = par;
            end
        end
        cw[POS_OVERALL] = ^cw;
        return cw;
    endfunction

    function automatic logic [MAX_W-1:0] extract(input logic [MAX_N-1:0] cw, input int width);
        logic [MAX_W-1:0] data;
        int               n;
        int               di;
        n    = width + calc_p(width) + 1;
        data = '0;
        di   = 0;
        for (int pos = POS_D0; pos < MAX_N; pos++) begin
            if (pos < n && !is_pow2(pos)) begin
                data[di] = cw[pos];
                di++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: codeword in, corrected data plus error class out.
// Zero latency; no handshake, output follows input.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int P     = calc_p(WIDTH),
    localparam int N     = WIDTH + P + 1
) (
    input  logic [N-1:0] cw,
    output dec_res_t     res
);

    logic [P-1:0]     syn;
    logic             overall;
    logic             in_range;
    logic [N-1:0]     flip;
    logic [MAX_N-1:0] fixed_ext;

    always_comb begin
        syn = '0;
        for (int pos = 1; pos < N; pos++)
            if (cw[pos]) syn = syn ^ pos[P-1:0];
        overall  = ^cw;
        // An odd-parity word pointing past the codeword is a multi-bit error.
        in_range = (int'(syn) < N);
        flip     = '0;
        if (overall && in_range) flip[syn] = 1'b1;
        fixed_ext         = '0;
        fixed_ext[N-1:0]  = cw ^ flip;
        res               = '0;
        res.data          = extract(fixed_ext, WIDTH);
        res.syndrome[P-1:0] = syn;
        res.sec           = overall && in_range;
        res.ded           = (!overall && syn != '0) || (overall && !in_range);
    end

endmodule

// File: rtl/hamming_secded_counter.sv
// Up-counter stored only as a SECDED codeword, scrubbed every cycle, with fault injection.
// Count visible same cycle; error flags one edge after the corrupt word; no backpressure.
module hamming_secded_counter
    import hamming_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CNT_W = 8,
    localparam int P     = calc_p(WIDTH),
    localparam int N     = WIDTH + P + 1,
    localparam int EPW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    input  logic             inj_en,
    input  logic [N-1:0]     inj_mask,
    output logic [WIDTH-1:0] counter,
    output logic             sec_err,
    output logic [EPW-1:0]   err_pos,
    output logic             ded_err,
    output logic [CNT_W-1:0] corr_cnt
);

    logic [N-1:0]       cw_q;
    logic [N-1:0]       cw_wr;
    dec_res_t           dec;
    logic [WIDTH-1:0]   d;
    logic [MAX_W-1:0]   enc_in;
    logic [MAX_N-1:0]   enc_full;
    logic               unused_bits;

    hamming_secded_dec #(.WIDTH(WIDTH)) u_dec (
        .cw  (cw_q),
        .res (dec)
    );

    assign d       = dec.data[WIDTH-1:0];
    assign counter = d;

    always_comb begin
        enc_in = '0;
        if (load)
            enc_in[WIDTH-1:0] = load_val;
        else if (enable)
            enc_in[WIDTH-1:0] = d + 1'b1;
        else
            enc_in[WIDTH-1:0] = d;
        enc_full = encode(enc_in, WIDTH);
        // An uncorrectable word is frozen for diagnosis until a load replaces it.
        if (!load && dec.ded)
            cw_wr = cw_q;
        else
            cw_wr = enc_full[N-1:0];
        if (inj_en)
            cw_wr = cw_wr ^ inj_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_q     <= '0;
            sec_err  <= 1'b0;
            err_pos  <= '0;
            ded_err  <= 1'b0;
            corr_cnt <= '0;
        end else begin
            cw_q    <= cw_wr;
            sec_err <= dec.sec;
            if (dec.sec)
                err_pos <= dec.syndrome[EPW-1:0];
            // A load discards the bad word, so it does not re-arm the sticky flag.
            if (dec.ded && !load)
                ded_err <= 1'b1;
            else if (err_clr)
                ded_err <= 1'b0;
            if (err_clr)
                corr_cnt <= dec.sec ? CNT_W'(1) : '0;
            else if (dec.sec && corr_cnt != '1)
                corr_cnt <= corr_cnt + 1'b1;
        end
    end

    assign unused_bits = ^{dec.data[MAX_W-1:WIDTH], dec.syndrome[MAX_P-1:EPW], enc_full[MAX_N-1:N]};

endmodule

// File: tb/tb_hamming_secded_counter.sv
module tb_hamming_secded_counter;

    localparam int W   = 16;
    localparam int N   = 22;
    localparam int EPW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           load;
    logic [W-1:0]   load_val;
    logic           err_clr;
    logic           inj_en;
    logic [N-1:0]   inj_mask;

    logic [W-1:0]   counter;
    logic           sec_err;
    logic [EPW-1:0] err_pos;
    logic           ded_err;
    logic [7:0]     corr_cnt;

    logic [W-1:0]   counter2;
    logic           sec_err2;
    logic [EPW-1:0] err_pos2;
    logic           ded_err2;
    logic [1:0]     corr_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_secded_counter #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_val(load_val),
        .err_clr(err_clr), .inj_en(inj_en), .inj_mask(inj_mask),
        .counter(counter), .sec_err(sec_err), .err_pos(err_pos),
        .ded_err(ded_err), .corr_cnt(corr_cnt)
    );

    hamming_secded_counter #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_val(load_val),
        .err_clr(err_clr), .inj_en(inj_en), .inj_mask(inj_mask),
        .counter(counter2), .sec_err(sec_err2), .err_pos(err_pos2),
        .ded_err(ded_err2), .corr_cnt(corr_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; load = 1'b0; load_val = '0;
        err_clr = 1'b0; inj_en = 1'b0; inj_mask = '0;
        tick();
        checks++; if (counter !== 16'd0) begin errors++; $display("FAIL rst_counter got %h want 0", counter); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL rst_sec got %b want 0", sec_err); end
        checks++; if (err_pos !== 5'd0) begin errors++; $display("FAIL rst_errpos got %0d want 0", err_pos); end
        checks++; if (ded_err !== 1'b0) begin errors++; $display("FAIL rst_ded got %b want 0", ded_err); end
        checks++; if (corr_cnt !== 8'd0) begin errors++; $display("FAIL rst_corr got %0d want 0", corr_cnt); end
        checks++; if (dut.cw_q !== 22'h0) begin errors++; $display("FAIL rst_cw got %h want 0", dut.cw_q); end
        rst = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_count();
        repeat (10) tick();
        checks++; if (counter !== 16'd10) begin errors++; $display("FAIL count10 got %0d want 10", counter); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL count_sec got %b want 0", sec_err); end
        checks++; if (ded_err !== 1'b0) begin errors++; $display("FAIL count_ded got %b want 0", ded_err); end
        checks++; if (corr_cnt !== 8'd0) begin errors++; $display("FAIL count_corr got %0d want 0", corr_cnt); end
    endtask

    task automatic test_inject_data();
        repeat (3) tick();
        checks++; if (counter !== 16'd13) begin errors++; $display("FAIL pre_inj got %0d want 13", counter); end
        inj_en = 1'b1; inj_mask = 22'h000008;
        tick();
        inj_en = 1'b0; inj_mask = '0;
        checks++; if (counter !== 16'd14) begin errors++; $display("FAIL inj_d0_cnt got %0d want 14", counter); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL inj_d0_early_sec got %b want 0", sec_err); end
        tick();
        checks++; if (counter !== 16'd15) begin errors++; $display("FAIL inj_d0_cnt15 got %0d want 15", counter); end
        checks++; if (sec_err !== 1'b1) begin errors++; $display("FAIL inj_d0_sec got %b want 1", sec_err); end
        checks++; if (err_pos !== 5'd3) begin errors++; $display("FAIL inj_d0_pos got %0d want 3", err_pos); end
        checks++; if (corr_cnt !== 8'd1) begin errors++; $display("FAIL inj_d0_corr got %0d want 1", corr_cnt); end
        tick();
        checks++; if (counter !== 16'd16) begin errors++; $display("FAIL inj_d0_cnt16 got %0d want 16", counter); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL inj_d0_pulse got %b want 0", sec_err); end
        checks++; if (err_pos !== 5'd3) begin errors++; $display("FAIL inj_d0_pos_hold got %0d want 3", err_pos); end
    endtask

    task automatic test_inject_overall();
        enable = 1'b0;
        inj_en = 1'b1; inj_mask = 22'h000001;
        tick();
        inj_en = 1'b0; inj_mask = '0;
        checks++; if (counter !== 16'd16) begin errors++; $display("FAIL ovl_cnt got %0d want 16", counter); end
        tick();
        checks++; if (sec_err !== 1'b1) begin errors++; $display("FAIL ovl_sec got %b want 1", sec_err); end
        checks++; if (err_pos !== 5'd0) begin errors++; $display("FAIL ovl_pos got %0d want 0", err_pos); end
        checks++; if (corr_cnt !== 8'd2) begin errors++; $display("FAIL ovl_corr got %0d want 2", corr_cnt); end
        checks++; if (dut.cw_q !== 22'h000303) begin errors++; $display("FAIL ovl_scrub got %h want 000303", dut.cw_q); end
        tick();
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL ovl_clean got %b want 0", sec_err); end
        checks++; if (counter !== 16'd16) begin errors++; $display("FAIL ovl_cnt_hold got %0d want 16", counter); end
    endtask

    task automatic test_ded();
        enable = 1'b1;
        inj_en = 1'b1; inj_mask = 22'h000028;
        tick();
        inj_en = 1'b0; inj_mask = '0;
        checks++; if (counter !== 16'd18) begin errors++; $display("FAIL ded_raw got %0d want 18", counter); end
        checks++; if (ded_err !== 1'b0) begin errors++; $display("FAIL ded_early got %b want 0", ded_err); end
        tick();
        checks++; if (ded_err !== 1'b1) begin errors++; $display("FAIL ded_set got %b want 1", ded_err); end
        checks++; if (counter !== 16'd18) begin errors++; $display("FAIL ded_frozen got %0d want 18", counter); end
        err_clr = 1'b1;
        tick();
        checks++; if (ded_err !== 1'b1) begin errors++; $display("FAIL ded_set_wins got %b want 1", ded_err); end
        checks++; if (counter !== 16'd18) begin errors++; $display("FAIL ded_frozen2 got %0d want 18", counter); end
        checks++; if (corr_cnt !== 8'd0) begin errors++; $display("FAIL ded_clr_corr got %0d want 0", corr_cnt); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL ded_no_sec got %b want 0", sec_err); end
        load = 1'b1; load_val = 16'h1234;
        tick();
        load = 1'b0; err_clr = 1'b0;
        checks++; if (counter !== 16'h1234) begin errors++; $display("FAIL ded_load got %h want 1234", counter); end
        checks++; if (ded_err !== 1'b0) begin errors++; $display("FAIL ded_cleared got %b want 0", ded_err); end
        tick();
        checks++; if (counter !== 16'h1235) begin errors++; $display("FAIL ded_resume got %h want 1235", counter); end
    endtask

    task automatic test_saturate();
        logic [N-1:0] masks [5];
        masks = '{22'h000004, 22'h000080, 22'h200000, 22'h010000, 22'h000400};
        for (int i = 0; i < 5; i++) begin
            inj_en = 1'b1; inj_mask = masks[i];
            tick();
            inj_en = 1'b0; inj_mask = '0;
            tick();
        end
        checks++; if (corr_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", corr_cnt2); end
        checks++; if (corr_cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got %0d want 5", corr_cnt); end
        checks++; if (err_pos !== 5'd10) begin errors++; $display("FAIL sat_pos got %0d want 10", err_pos); end
        checks++; if (counter !== 16'h123F) begin errors++; $display("FAIL sat_counter got %h want 123f", counter); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (corr_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr2 got %0d want 0", corr_cnt2); end
        checks++; if (corr_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr8 got %0d want 0", corr_cnt); end
        inj_en = 1'b1; inj_mask = 22'h000010;
        tick();
        inj_en = 1'b0; inj_mask = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (corr_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_sec got %0d want 1", corr_cnt); end
        checks++; if (corr_cnt2 !== 2'd1) begin errors++; $display("FAIL clr_with_sec2 got %0d want 1", corr_cnt2); end
        checks++; if (err_pos !== 5'd4) begin errors++; $display("FAIL clr_pos got %0d want 4", err_pos); end
        checks++; if (counter !== 16'h1242) begin errors++; $display("FAIL clr_counter got %h want 1242", counter); end
    endtask

    task automatic test_wrap_reset();
        enable = 1'b0; load = 1'b1; load_val = 16'hFFFF;
        tick();
        load = 1'b0; enable = 1'b1;
        checks++; if (counter !== 16'hFFFF) begin errors++; $display("FAIL wrap_load got %h want ffff", counter); end
        tick();
        checks++; if (counter !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", counter); end
        inj_en = 1'b1; inj_mask = 22'h000028;
        tick();
        inj_en = 1'b0; inj_mask = '0;
        checks++; if (counter !== 16'd2) begin errors++; $display("FAIL wrap_ded_raw got %0d want 2", counter); end
        tick();
        checks++; if (ded_err !== 1'b1) begin errors++; $display("FAIL wrap_ded got %b want 1", ded_err); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (counter !== 16'd0) begin errors++; $display("FAIL arst_counter got %h want 0", counter); end
        checks++; if (ded_err !== 1'b0) begin errors++; $display("FAIL arst_ded got %b want 0", ded_err); end
        checks++; if (err_pos !== 5'd0) begin errors++; $display("FAIL arst_pos got %0d want 0", err_pos); end
        checks++; if (corr_cnt !== 8'd0) begin errors++; $display("FAIL arst_corr got %0d want 0", corr_cnt); end
        checks++; if (corr_cnt2 !== 2'd0) begin errors++; $display("FAIL arst_corr2 got %0d want 0", corr_cnt2); end
        checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL arst_sec got %b want 0", sec_err); end
        rst = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_inject_data();
        test_inject_overall();
        test_ded();
        test_saturate();
        test_wrap_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
